audio_envelope_expander: RTL and testbench
==========================================

// Module: audio_envelope_expander
// PURPOSE
//   Consumer of per-interval min/max amplitude pairs: regenerates a peak-envelope
//   sample stream, interval_len samples per pair, alternating max,min,max,...
//   Sits downstream of the interval min/max stage and feeds playback/plot logic.
//   Valid/ready on both sides; a one-entry prefetch buffer hides the inter-interval bubble.
// PARAMETERS
//   DATA_W        32  sample/amplitude width, two's complement
//   LEN_W         16  width of interval_len
//   NUM_INTERVALS 10  pairs consumed per frame (one start -> one frame)
// PORTS
//   clk           in   1       rising-edge clock
//   reset_n       in   1       asynchronous, active-low reset
//   start         in   1       begin a frame; sampled only in IDLE
//   interval_len  in   LEN_W   samples emitted per pair; latched on start
//   in_valid      in   1       pair valid
//   in_ready      out  1       pair accepted when in_valid & in_ready
//   in_max        in   DATA_W  signed interval maximum
//   in_min        in   DATA_W  signed interval minimum
//   out_valid     out  1       out_sample valid
//   out_ready     in   1       sample consumed when out_valid & out_ready
//   out_sample    out  DATA_W  signed envelope sample
//   out_last_int  out  1       qualifies last sample of current interval
//   out_last      out  1       qualifies last sample of the frame
//   busy          out  1       high from accepted start until DONE exits
//   done          out  1       one-cycle pulse at frame end
//   err_order     out  1       sticky: some pair had in_min > in_max; cleared on start
// BEHAVIOUR
//   Reset (reset_n=0, any time, async): state=IDLE; in_ready, out_valid, out_sample,
//     out_last_int, out_last, busy, done, err_order all 0; counters and prefetch
//     buffer cleared. Frame in progress is abandoned; no partial output after release.
//   States: IDLE -> FETCH -> EMIT -> (FETCH | DONE) -> IDLE.
//   IDLE: on start: latch len = (interval_len==0) ? 1 : interval_len; clear
//     sample_cnt, int_idx, err_order; busy<=1; go FETCH. Otherwise hold.
//   FETCH: if prefetch buffer full, load current pair from it (no input beat) and go
//     EMIT next cycle; else in_ready=1, on handshake load pair, go EMIT next cycle.
//   Pair load: if min > max (signed), swap, set err_order. Current pair held in regs.
//   EMIT: out_valid=1; out_sample = (sample_cnt[0]==0) ? max : min.
//     out_sample, out_last_int, out_last stable while out_valid & !out_ready.
//     On output handshake: sample_cnt++; if sample_cnt==len-1: sample_cnt<=0,
//     int_idx++, go DONE if int_idx==NUM_INTERVALS-1 else FETCH.
//     out_last_int = (sample_cnt==len-1); out_last = out_last_int & (int_idx==NUM_INTERVALS-1).
//   Prefetch: during EMIT, in_ready = !buf_full & (int_idx < NUM_INTERVALS-1);
//     accepted pair written to buffer (swap/err rule applied at write).
//     Never accepts more than NUM_INTERVALS pairs per frame.
//   DONE: done=1 for exactly one cycle, busy<=0, go IDLE. out_valid=0.
//   start while busy: ignored. Simultaneous output handshake and prefetch write in
//     the same cycle are both honoured.
//   Latency: first out_valid the cycle after the first pair handshake. Back-to-back
//     intervals with buffer full: one idle cycle (FETCH) between intervals.
//   Widths: sample_cnt LEN_W bits; int_idx $clog2(NUM_INTERVALS)+1 bits; signed
//     compare only on min/max; no arithmetic on samples.
// TESTING
//   1 len=4, NUM_INTERVALS=2, pairs (max=100,min=-100),(50,-20), out_ready=1 ->
//     stream 100,-100,100,-100,50,-20,50,-20; out_last_int on beats 4,8; out_last on 8; done 1 cycle.
//   2 len=3, out_ready toggled 1/0 each cycle -> same 3-sample pattern, sample held
//     stable across stall cycles, no duplicates or drops.
//   3 pair (max=-5,min=7) -> emitted as 7,-5,...; err_order=1 until next start.
//   4 interval_len=0 -> treated as 1: one sample (max) per pair, out_last_int every beat.
//   5 reset_n low mid-EMIT of interval 3 -> all outputs 0 immediately; after release,
//     start with fresh pairs yields a clean full frame from interval 0.
//   6 in_valid held high from start, out_ready=1 -> buffer fills during EMIT; exactly
//     NUM_INTERVALS handshakes, in_ready stays 0 after last pair accepted.

Source files
------------

// File: rtl/audio_envelope_expander.sv
// Expands per-interval (max,min) amplitude pairs into an alternating peak-envelope
// sample stream, interval_len samples per pair, with a one-entry prefetch buffer.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; outputs quiet
//   S_FETCH | load current pair from prefetch buffer or input handshake
//   S_EMIT  | stream max,min,... for current pair; prefetch next pair
//   S_DONE  | one-cycle done pulse, then back to idle
module audio_envelope_expander #(
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 16,
    parameter int NUM_INTERVALS = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         interval_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_max,
    input  logic signed [DATA_W-1:0] in_min,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_last_int,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err_order
);

    localparam int IDX_W = $clog2(NUM_INTERVALS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INTERVALS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          sample_cnt_q, sample_cnt_d;
    logic [IDX_W-1:0]          int_idx_q, int_idx_d;
    logic signed [DATA_W-1:0]  cur_max_q, cur_max_d;
    logic signed [DATA_W-1:0]  cur_min_q, cur_min_d;
    logic signed [DATA_W-1:0]  buf_max_q, buf_max_d;
    logic signed [DATA_W-1:0]  buf_min_q, buf_min_d;
    logic                      buf_full_q, buf_full_d;
    logic                      err_q, err_d;

    // Incoming pair normalised so that hi >= lo; swap flags an ordering error.
    logic                      in_swap;
    logic signed [DATA_W-1:0]  in_hi, in_lo;
    logic                      last_int;

    assign in_swap  = (in_min > in_max);
    assign in_hi    = in_swap ? in_min : in_max;
    assign in_lo    = in_swap ? in_max : in_min;
    assign last_int = (sample_cnt_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            sample_cnt_q <= '0;
            int_idx_q    <= '0;
            cur_max_q    <= '0;
            cur_min_q    <= '0;
            buf_max_q    <= '0;
            buf_min_q    <= '0;
            buf_full_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sample_cnt_q <= sample_cnt_d;
            int_idx_q    <= int_idx_d;
            cur_max_q    <= cur_max_d;
            cur_min_q    <= cur_min_d;
            buf_max_q    <= buf_max_d;
            buf_min_q    <= buf_min_d;
            buf_full_q   <= buf_full_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sample_cnt_d = sample_cnt_q;
        int_idx_d    = int_idx_q;
        cur_max_d    = cur_max_q;
        cur_min_d    = cur_min_q;
        buf_max_d    = buf_max_q;
        buf_min_d    = buf_min_q;
        buf_full_d   = buf_full_q;
        err_d        = err_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d        = (interval_len == '0) ? LEN_W'(1) : interval_len;
                    sample_cnt_d = '0;
                    int_idx_d    = '0;
                    err_d        = 1'b0;
                    buf_full_d   = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (buf_full_q) begin
                    cur_max_d  = buf_max_q;
                    cur_min_d  = buf_min_q;
                    buf_full_d = 1'b0;
                    state_d    = S_EMIT;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        cur_max_d = in_hi;
                        cur_min_d = in_lo;
                        if (in_swap) err_d = 1'b1;
                        state_d   = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                // Only the next pair of this frame may be prefetched.
                in_ready  = !buf_full_q && (int_idx_q < LAST_IDX);
                if (in_valid && in_ready) begin
                    buf_max_d  = in_hi;
                    buf_min_d  = in_lo;
                    buf_full_d = 1'b1;
                    if (in_swap) err_d = 1'b1;
                end
                if (out_ready) begin
                    if (last_int) begin
                        sample_cnt_d = '0;
                        int_idx_d    = int_idx_q + IDX_W'(1);
                        state_d      = (int_idx_q == LAST_IDX) ? S_DONE : S_FETCH;
                    end else begin
                        sample_cnt_d = sample_cnt_q + LEN_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_sample   = !out_valid ? '0 : (sample_cnt_q[0] ? cur_min_q : cur_max_q);
    assign out_last_int = (state_q == S_EMIT) && last_int;
    assign out_last     = out_last_int && (int_idx_q == LAST_IDX);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err_order    = err_q;

endmodule

// File: tb/tb_audio_envelope_expander.sv
// Directed bench for audio_envelope_expander (NUM_INTERVALS=4): frame streams,
// stalls, swapped pairs, zero length, mid-frame reset and continuous input valid.
module tb_audio_envelope_expander;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [15:0]        interval_len;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_max;
    logic signed [31:0] in_min;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_sample;
    logic               out_last_int;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               err_order;

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [31:0] pmax [N];
    logic signed [31:0] pmin [N];
    logic signed [31:0] xmax [N];
    logic signed [31:0] xmin [N];

    audio_envelope_expander #(
        .DATA_W(32),
        .LEN_W(16),
        .NUM_INTERVALS(N)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .interval_len(interval_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_max      (in_max),
        .in_min      (in_min),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sample  (out_sample),
        .out_last_int(out_last_int),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err_order   (err_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs,
                   $signed(exp), exp);
        end
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start        = 1'b1;
        interval_len = 16'(len);
        @(negedge clk);
        start        = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
        chk("err_cleared_on_start", err_order, 0);
    endtask

    // Drives pairs and consumes samples until done (or abort_at beats), checking
    // every beat against the expected envelope built from xmax/xmin.
    task automatic run_frame(input int len_eff, input int abort_at, input bit stall,
                             input bit hold_valid, input bit poke_start, input logic exp_err);
        int pi = 0;
        int bi = 0;
        int cyc = 0;
        int gaps = 0;
        int dones = 0;
        int done_cyc = 0;
        bit seen_first = 0;
        bit lat_pending = 0;
        bit lat_done = 0;
        bit held_v = 0;
        logic [31:0] held_s = '0;
        logic held_li = 0;
        logic held_l = 0;
        int pr, sp;
        logic signed [31:0] es;
        logic eli, el;
        forever begin
            in_valid  = (pi < N) || hold_valid;
            in_max    = (pi < N) ? pmax[pi] : 32'sd12345;
            in_min    = (pi < N) ? pmin[pi] : -32'sd12345;
            out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            start     = poke_start && (cyc == 3);
            interval_len = 16'd7;
            #1;
            if (lat_pending) begin
                chk("first_out_latency", out_valid, 1);
                lat_pending = 0;
            end
            if (held_v) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_sample_stable", out_sample, held_s);
                chk("stall_last_int_stable", out_last_int, held_li);
                chk("stall_last_stable", out_last, held_l);
                held_v = 0;
            end
            if (out_valid) begin
                seen_first = 1;
                if (out_ready) begin
                    pr  = bi / len_eff;
                    sp  = bi % len_eff;
                    es  = (sp % 2 == 0) ? xmax[pr % N] : xmin[pr % N];
                    eli = (sp == len_eff - 1);
                    el  = eli && (pr == N - 1);
                    chk($sformatf("sample[%0d]", bi), out_sample, es);
                    chk($sformatf("last_int[%0d]", bi), out_last_int, eli);
                    chk($sformatf("last[%0d]", bi), out_last, el);
                    bi++;
                end else begin
                    held_v  = 1;
                    held_s  = out_sample;
                    held_li = out_last_int;
                    held_l  = out_last;
                end
            end else if (seen_first && bi < N * len_eff) begin
                gaps++;
            end
            if (pi >= N) chk("in_ready_low_after_last_pair", in_ready, 0);
            if (in_valid && in_ready && pi < N) begin
                pi++;
                if (!lat_done) begin
                    lat_pending = 1;
                    lat_done    = 1;
                end
            end
            if (dones > 0 && cyc == done_cyc + 1) begin
                chk("done_one_cycle", done, 0);
                chk("busy_low_after_done", busy, 0);
                break;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk("out_valid_low_in_done", out_valid, 0);
                chk("busy_high_in_done", busy, 1);
            end
            if (abort_at > 0 && bi == abort_at) begin
                start = 1'b0;
                return;
            end
            if (cyc >= 400) begin
                chk("frame_timeout", 0, 1);
                break;
            end
            cyc++;
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("beats_total", bi, N * len_eff);
        chk("pairs_accepted", pi, N);
        chk("done_pulses", dones, 1);
        chk("fetch_gaps", gaps, N - 1);
        chk("err_order_end", err_order, exp_err);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        interval_len = '0;
        in_valid     = 1'b0;
        in_max       = '0;
        in_min       = '0;
        out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_out_last_int", out_last_int, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_order", err_order, 0);
        reset_n = 1'b1;

        // Basic frame, len 4; a start pulse mid-frame must be ignored.
        pmax = '{100, 50, 7, -1};
        pmin = '{-100, -20, 3, -8};
        xmax = pmax;
        xmin = pmin;
        do_start(4);
        run_frame(4, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Output stalls every other cycle, len 3.
        pmax = '{1000, -3, 0, 42};
        pmin = '{-1000, -4, -7, 41};
        xmax = pmax;
        xmin = pmin;
        do_start(3);
        run_frame(3, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Swapped pair (max=-5,min=7) emitted as 7,-5; equal pair is not an error.
        pmax = '{10, -5, 20, 30};
        pmin = '{0, 7, -20, 30};
        xmax = '{10, 7, 20, 30};
        xmin = '{0, -5, -20, 30};
        do_start(2);
        run_frame(2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("err_order_sticky_idle", err_order, 1);

        // Zero length behaves as one sample (max) per pair.
        pmax = '{5, 6, -7, 8};
        pmin = '{1, 2, -9, -8};
        xmax = pmax;
        xmin = pmin;
        do_start(0);
        run_frame(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during the third interval, then a clean frame.
        pmax = '{1, 22, 33, 44};
        pmin = '{2, -22, -33, -44};
        xmax = '{2, 22, 33, 44};
        xmin = '{1, -22, -33, -44};
        do_start(3);
        run_frame(3, 7, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_out_valid", out_valid, 1);
        chk("pre_reset_err_order", err_order, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_sample", out_sample, 0);
        chk("midrst_out_last_int", out_last_int, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err_order", err_order, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_quiet_valid", out_valid, 0);
        chk("post_rst_quiet_busy", busy, 0);
        pmax = '{11, 22, 33, 44};
        pmin = '{-11, -22, -33, -44};
        xmax = pmax;
        xmin = pmin;
        do_start(3);
        run_frame(3, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // in_valid held high throughout: exactly N pairs taken.
        pmax = '{9, 8, 7, 6};
        pmin = '{-9, -8, -7, -6};
        xmax = pmax;
        xmin = pmin;
        do_start(2);
        run_frame(2, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
